// File: rtl/evict_data_buf_if.sv
// Bus bundle for the evict data buffer: per-lane eviction writes in, one drain port out.
// The payload type lives in vector_cache_pkg, which is guarded so either rtl file may be read first.
`ifndef VECTOR_CACHE_PKG_DEFINED
`define VECTOR_CACHE_PKG_DEFINED
package vector_cache_pkg;
    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } group_data_pld_t;
endpackage
`endif

interface evict_data_buf_if;
    import vector_cache_pkg::*;

    logic [3:0]            evict_data_out_vld_to_evdb;
    group_data_pld_t [3:0] evict_data_out_to_evdb;
    logic                  evdb_out_vld;
    group_data_pld_t       evdb_out_pld;
    logic [1:0]            evdb_out_lane;
    logic                  evdb_out_rdy;
    logic [3:0]            evdb_afull;
    logic                  evdb_empty;
    logic                  evdb_ovf_err;

    // master: the scheduler / write-path side that feeds and drains the buffer
    modport master (
        output evict_data_out_vld_to_evdb,
        output evict_data_out_to_evdb,
        output evdb_out_rdy,
        input  evdb_out_vld,
        input  evdb_out_pld,
        input  evdb_out_lane,
        input  evdb_afull,
        input  evdb_empty,
        input  evdb_ovf_err
    );

    modport slave (
        input  evict_data_out_vld_to_evdb,
        input  evict_data_out_to_evdb,
        input  evdb_out_rdy,
        output evdb_out_vld,
        output evdb_out_pld,
        output evdb_out_lane,
        output evdb_afull,
        output evdb_empty,
        output evdb_ovf_err
    );
endinterface

// File: rtl/evict_data_buf.sv
// Evict data buffer: four per-lane FIFOs drained one line per cycle by a round-robin arbiter.
// Define EVDB_OVF_CHK_EN to build the sticky overflow detector (evdb_ovf_err tied low otherwise).
`ifndef VECTOR_CACHE_PKG_DEFINED
`define VECTOR_CACHE_PKG_DEFINED
package vector_cache_pkg;
    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } group_data_pld_t;
endpackage
`endif

module evict_data_buf
    import vector_cache_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    evict_data_buf_if.slave evdb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - AFULL_LVL);

    logic [3:0]      lane_nz;
    logic [3:0]      lane_full;
    logic [3:0]      push;
    logic [3:0]      pop;
    logic [3:0]      cnt_d_zero;
    logic [3:0]      afull_d;
    logic [3:0]      afull_q;
    group_data_pld_t head_pld [4];

    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] grant_idx;
    logic [1:0] arb_cand;
    logic       grant_vld;
    logic       handshake;
    logic       empty_q, empty_d;

    // First non-empty lane at or after rr_ptr, wrapping 3 -> 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        arb_cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            arb_cand = rr_ptr_q + 2'(k);
            if (!grant_vld && lane_nz[arb_cand]) begin
                grant_vld = 1'b1;
                grant_idx = arb_cand;
            end
        end
    end

    assign handshake = grant_vld && evdb.evdb_out_rdy;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [PW-1:0]   wptr_q, wptr_d;
        logic [PW-1:0]   rptr_q, rptr_d;
        logic [CW-1:0]   cnt_q, cnt_d;
        group_data_pld_t mem [DEPTH];

        assign lane_nz[gi]   = (cnt_q != '0);
        assign lane_full[gi] = (cnt_q == FULL_CNT);
        assign pop[gi]       = handshake && (grant_idx == 2'(gi));
        // A full lane still takes a write when its head leaves in the same cycle.
        assign push[gi]      = evdb.evict_data_out_vld_to_evdb[gi] && (!lane_full[gi] || pop[gi]);

        always_comb begin
            wptr_d = wptr_q + PW'(push[gi]);
            rptr_d = rptr_q + PW'(pop[gi]);
            cnt_d  = cnt_q + CW'(push[gi]) - CW'(pop[gi]);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push[gi]) begin
                mem[wptr_q] <= evdb.evict_data_out_to_evdb[gi];
            end
        end

        assign head_pld[gi]   = mem[rptr_q];
        assign cnt_d_zero[gi] = (cnt_d == '0);
        assign afull_d[gi]    = (cnt_d >= AFULL_CNT);
    end

    always_comb begin
        rr_ptr_d = handshake ? (grant_idx + 2'd1) : rr_ptr_q;
        empty_d  = &cnt_d_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
            afull_q  <= 4'd0;
            empty_q  <= 1'b1;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
        end
    end

`ifdef EVDB_OVF_CHK_EN
    logic [3:0] ovf_evt;
    logic       ovf_err_q, ovf_err_d;

    for (genvar gi = 0; gi < 4; gi++) begin : g_ovf
        assign ovf_evt[gi] = evdb.evict_data_out_vld_to_evdb[gi] && lane_full[gi] && !pop[gi];
`ifndef SYNTHESIS
        always @(posedge clk) begin
            if (rst_n && ovf_evt[gi]) begin
                $error("evict_data_buf: write dropped on full lane %0d", gi);
            end
        end
`endif
    end

    always_comb begin
        ovf_err_d = ovf_err_q | (|ovf_evt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
        end
    end

    assign evdb.evdb_ovf_err = ovf_err_q;
`else
    assign evdb.evdb_ovf_err = 1'b0;
`endif

    // Drain port is combinational from registered FIFO state, giving one-cycle write-to-drain.
    assign evdb.evdb_out_vld  = grant_vld;
    assign evdb.evdb_out_lane = grant_idx;
    assign evdb.evdb_out_pld  = grant_vld ? head_pld[grant_idx] : '0;
    assign evdb.evdb_afull    = afull_q;
    assign evdb.evdb_empty    = empty_q;

endmodule

// File: tb/tb_evict_data_buf.sv
// Self-checking bench for evict_data_buf: queue-based lane model, per-cycle compare, directed and random traffic.
module tb_evict_data_buf;
    import vector_cache_pkg::*;

    localparam int DEPTH     = 4;
    localparam int AFULL_LVL = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    evict_data_buf_if evdb_if();

    evict_data_buf #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .evdb (evdb_if)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: one queue per lane plus the round-robin pointer.
    group_data_pld_t mq [4][$];
    int              m_rr;
    bit              m_ovf;

    logic            exp_vld;
    logic [1:0]      exp_lane;
    group_data_pld_t exp_pld;
    logic [3:0]      exp_afull;
    logic            exp_empty;
    logic            exp_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        int g = -1;
        for (int k = 0; k < 4; k++) begin
            int l = (m_rr + k) % 4;
            if (g < 0 && mq[l].size() > 0) g = l;
        end
        return g;
    endfunction

    task automatic model_outputs();
        int g = model_grant();
        exp_vld   = (g >= 0);
        exp_lane  = (g >= 0) ? 2'(g) : 2'd0;
        exp_pld   = (g >= 0) ? mq[g][0] : '0;
        exp_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_afull[i] = (mq[i].size() >= DEPTH - AFULL_LVL);
            if (mq[i].size() != 0) exp_empty = 1'b0;
        end
        exp_ovf = m_ovf;
    endtask

    task automatic model_step(input logic [3:0] v, input group_data_pld_t [3:0] p, input logic r);
        int g = model_grant();
        if (g >= 0 && r) begin
            void'(mq[g].pop_front());
            m_rr = (g + 1) % 4;
        end
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(p[i]);
`ifdef EVDB_OVF_CHK_EN
                else m_ovf = 1'b1;
`endif
            end
        end
        model_outputs();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_rr  = 0;
        m_ovf = 1'b0;
        model_outputs();
    endtask

    function automatic group_data_pld_t rand_pld();
        group_data_pld_t x;
        x.tag  = 8'($urandom);
        x.data = $urandom;
        return x;
    endfunction

    // One clock: inputs driven from posedge+1, consumed at the next posedge.
    task automatic cycle(input logic [3:0] v, input group_data_pld_t [3:0] p, input logic r);
        evdb_if.evict_data_out_vld_to_evdb = v;
        evdb_if.evict_data_out_to_evdb     = p;
        evdb_if.evdb_out_rdy               = r;
        @(posedge clk);
        model_step(v, p, r);
        #1;
        evdb_if.evict_data_out_vld_to_evdb = 4'd0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_vld", 64'(evdb_if.evdb_out_vld), 64'd0);
        chk("rst_async_empty", 64'(evdb_if.evdb_empty), 64'd1);
        evdb_if.evict_data_out_vld_to_evdb = 4'd0;
        evdb_if.evdb_out_rdy               = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("vld", 64'(evdb_if.evdb_out_vld), 64'(exp_vld));
            if (exp_vld) chk("lane", 64'(evdb_if.evdb_out_lane), 64'(exp_lane));
            chk("pld", 64'(evdb_if.evdb_out_pld), 64'(exp_pld));
            chk("afull", 64'(evdb_if.evdb_afull), 64'(exp_afull));
            chk("empty", 64'(evdb_if.evdb_empty), 64'(exp_empty));
            chk("ovf_err", 64'(evdb_if.evdb_ovf_err), 64'(exp_ovf));
        end
    end

    initial begin
        group_data_pld_t [3:0] p;
        group_data_pld_t       held_pld;
        logic [1:0]            held_lane;
        int                    drained;

        rst_n = 1'b0;
        evdb_if.evict_data_out_vld_to_evdb = 4'd0;
        evdb_if.evict_data_out_to_evdb     = '0;
        evdb_if.evdb_out_rdy               = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset_vld", 64'(evdb_if.evdb_out_vld), 64'd0);
        chk("reset_lane", 64'(evdb_if.evdb_out_lane), 64'd0);
        chk("reset_pld", 64'(evdb_if.evdb_out_pld), 64'd0);
        chk("reset_afull", 64'(evdb_if.evdb_afull), 64'd0);
        chk("reset_empty", 64'(evdb_if.evdb_empty), 64'd1);
        chk("reset_ovf", 64'(evdb_if.evdb_ovf_err), 64'd0);
        chk_en = 1'b1;

        // Single write to lane 2 with rdy high.
        p = '0;
        p[2] = 40'hA5_DEAD_BEEF;
        cycle(4'b0100, p, 1'b1);
        chk("single_vld", 64'(evdb_if.evdb_out_vld), 64'd1);
        chk("single_lane", 64'(evdb_if.evdb_out_lane), 64'd2);
        chk("single_pld", 64'(evdb_if.evdb_out_pld), 64'hA5_DEAD_BEEF);
        chk("single_model_lane", 64'(exp_lane), 64'd2);
        cycle(4'b0000, p, 1'b1);
        chk("single_drained_vld", 64'(evdb_if.evdb_out_vld), 64'd0);
        chk("single_drained_empty", 64'(evdb_if.evdb_empty), 64'd1);

        // Fairness from rr_ptr=0: drain order 0,1,2,3.
        do_reset();
        for (int i = 0; i < 4; i++) p[i] = rand_pld();
        cycle(4'b1111, p, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr0_order%0d", i), 64'(evdb_if.evdb_out_lane), 64'(i));
            chk($sformatf("rr0_pld%0d", i), 64'(evdb_if.evdb_out_pld), 64'(p[i]));
            cycle(4'b0000, p, 1'b1);
        end
        chk("rr0_empty", 64'(evdb_if.evdb_empty), 64'd1);

        // Fairness from rr_ptr=2 (one pop of lane 1 moves it there): order 2,3,0,1.
        do_reset();
        p[1] = rand_pld();
        cycle(4'b0010, p, 1'b1);
        cycle(4'b0000, p, 1'b1);
        for (int i = 0; i < 4; i++) p[i] = rand_pld();
        cycle(4'b1111, p, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr2_order%0d", i), 64'(evdb_if.evdb_out_lane), 64'((i + 2) % 4));
            cycle(4'b0000, p, 1'b1);
        end

        // Stall: two lines held for 5 cycles, then two back-to-back accepts.
        do_reset();
        for (int i = 0; i < 4; i++) p[i] = rand_pld();
        cycle(4'b1001, p, 1'b0);
        held_pld  = evdb_if.evdb_out_pld;
        held_lane = evdb_if.evdb_out_lane;
        chk("stall_first_lane", 64'(held_lane), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0000, p, 1'b0);
            chk($sformatf("stall_pld%0d", i), 64'(evdb_if.evdb_out_pld), 64'(held_pld));
            chk($sformatf("stall_lane%0d", i), 64'(evdb_if.evdb_out_lane), 64'(held_lane));
        end
        cycle(4'b0000, p, 1'b1);
        chk("stall_second_lane", 64'(evdb_if.evdb_out_lane), 64'd3);
        chk("stall_second_pld", 64'(evdb_if.evdb_out_pld), 64'(p[3]));
        cycle(4'b0000, p, 1'b1);
        chk("stall_done", 64'(evdb_if.evdb_out_vld), 64'd0);

        // Almost-full on lane 1.
        do_reset();
        p[1] = rand_pld();
        cycle(4'b0010, p, 1'b0);
        chk("afull_after1", 64'(evdb_if.evdb_afull), 64'b0000);
        cycle(4'b0010, p, 1'b0);
        chk("afull_after2", 64'(evdb_if.evdb_afull), 64'b0010);
        cycle(4'b0000, p, 1'b1);
        chk("afull_after_pop", 64'(evdb_if.evdb_afull), 64'b0000);

        // Overflow on lane 3: five writes, only four survive.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            p[3] = rand_pld();
            cycle(4'b1000, p, 1'b0);
        end
`ifdef EVDB_OVF_CHK_EN
        chk("ovf_set", 64'(evdb_if.evdb_ovf_err), 64'd1);
`else
        chk("ovf_tied", 64'(evdb_if.evdb_ovf_err), 64'd0);
`endif
        drained = 0;
        for (int i = 0; i < 10; i++) begin
            if (evdb_if.evdb_out_vld) drained++;
            cycle(4'b0000, p, 1'b1);
        end
        chk("ovf_drain_count", 64'(drained), 64'd4);
`ifdef EVDB_OVF_CHK_EN
        chk("ovf_sticky", 64'(evdb_if.evdb_ovf_err), 64'd1);
`endif

        // Full lane 0 popped and written in the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            p[0] = rand_pld();
            cycle(4'b0001, p, 1'b0);
        end
        p[0] = 40'h3C_1234_5678;
        cycle(4'b0001, p, 1'b1);
        chk("fullpop_afull", 64'(evdb_if.evdb_afull), 64'b0001);
        chk("fullpop_ovf", 64'(evdb_if.evdb_ovf_err), 64'd0);
        drained = 0;
        held_pld = '0;
        for (int i = 0; i < 8; i++) begin
            if (evdb_if.evdb_out_vld) begin
                drained++;
                held_pld = evdb_if.evdb_out_pld;
            end
            cycle(4'b0000, p, 1'b1);
        end
        chk("fullpop_count", 64'(drained), 64'd4);
        chk("fullpop_last_pld", 64'(held_pld), 64'h3C_1234_5678);

        // Random traffic with an asynchronous reset partway through.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] v;
            logic       r;
            for (int i = 0; i < 4; i++) begin
                v[i] = ($urandom_range(0, 2) == 0);
                p[i] = rand_pld();
            end
            r = ((c / 200) % 3 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            cycle(v, p, r);
            if (c == 1500) do_reset();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
